// File: rtl/literal_formatter.sv
// Streams an unsigned value as an ASCII based literal such as 16#12AF#.
// Digits are produced LSB-first into a buffer, then emitted MSB-first over a valid/ready byte stream.
module literal_formatter #(
    parameter int W = 16
) (
    input  logic         sysclk,
    input  logic         rstn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] value,
    input  logic [1:0]   radix,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [7:0]   out_char,
    output logic         out_last
);

    localparam int NW = $clog2(W + 1);
    localparam int AW = $clog2(W);
    localparam logic [NW-1:0] N_ONE    = 1;
    localparam logic [NW-1:0] N_TWO    = 2;
    localparam logic [AW-1:0] C_ONE    = 1;
    localparam logic [AW-1:0] DIV_LAST = AW'(W - 1);

    typedef enum logic [2:0] {
        IDLE,
        CONV,
        DIV,
        PREFIX,
        HASH1,
        DIGITS,
        HASH2
    } state_t;

    state_t        state;
    logic [W-1:0]  q;
    logic [1:0]    radix_r;
    logic [NW-1:0] n;
    logic [3:0]    digits [W];
    logic [3:0]    rem;
    logic [AW-1:0] div_cnt;
    logic          prefix_second;

    logic [W-1:0]  q_shift;
    logic [3:0]    low_digit;
    logic [4:0]    trial;
    logic          trial_ge;
    logic [3:0]    rem_next;
    logic [W-1:0]  quo_next;
    logic [NW-1:0] n_inc;
    logic [NW-1:0] n_dec;
    logic [NW-1:0] n_dec2;
    logic [7:0]    prefix_first;

    function automatic logic [7:0] to_ascii(input logic [3:0] d);
        return (d < 4'd10) ? (8'h30 + {4'h0, d}) : (8'h37 + {4'h0, d});
    endfunction

    // Power-of-two radices peel off the low bits directly.
    always_comb begin
        q_shift   = q >> 1;
        low_digit = {3'b000, q[0]};
        case (radix_r)
            2'b01: begin
                q_shift   = q >> 3;
                low_digit = {1'b0, q[2:0]};
            end
            2'b11: begin
                q_shift   = q >> 4;
                low_digit = q[3:0];
            end
            default: begin
                q_shift   = q >> 1;
                low_digit = {3'b000, q[0]};
            end
        endcase
    end

    // One restoring-division step: shift the next dividend bit into the remainder and try subtracting 10.
    always_comb begin
        trial    = {rem, q[W-1]};
        trial_ge = (trial >= 5'd10);
        rem_next = trial_ge ? (trial[3:0] - 4'd10) : trial[3:0];
        quo_next = {q[W-2:0], trial_ge};
    end

    always_comb begin
        n_inc  = n + N_ONE;
        n_dec  = n - N_ONE;
        n_dec2 = n - N_TWO;
        case (radix_r)
            2'b00:   prefix_first = 8'h32;
            2'b01:   prefix_first = 8'h38;
            default: prefix_first = 8'h31;
        endcase
    end

    always_ff @(posedge sysclk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            in_ready      <= 1'b1;
            out_valid     <= 1'b0;
            out_char      <= 8'h00;
            out_last      <= 1'b0;
            q             <= '0;
            radix_r       <= 2'b00;
            n             <= '0;
            rem           <= 4'h0;
            div_cnt       <= '0;
            prefix_second <= 1'b0;
            for (int i = 0; i < W; i++) begin
                digits[i] <= 4'h0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        q        <= value;
                        radix_r  <= radix;
                        n        <= '0;
                        in_ready <= 1'b0;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    if (radix_r == 2'b10) begin
                        rem     <= 4'h0;
                        div_cnt <= '0;
                        state   <= DIV;
                    end else begin
                        digits[n[AW-1:0]] <= low_digit;
                        q                 <= q_shift;
                        n                 <= n_inc;
                        if (q_shift == '0) begin
                            state         <= PREFIX;
                            out_valid     <= 1'b1;
                            out_char      <= prefix_first;
                            prefix_second <= 1'b0;
                        end
                    end
                end
                DIV: begin
                    q       <= quo_next;
                    rem     <= rem_next;
                    div_cnt <= div_cnt + C_ONE;
                    if (div_cnt == DIV_LAST) begin
                        digits[n[AW-1:0]] <= rem_next;
                        n                 <= n_inc;
                        div_cnt           <= '0;
                        if (quo_next == '0) begin
                            state         <= PREFIX;
                            out_valid     <= 1'b1;
                            out_char      <= prefix_first;
                            prefix_second <= 1'b0;
                        end else begin
                            state <= CONV;
                        end
                    end
                end
                PREFIX: begin
                    // Radix 10 and 16 need a second prefix character.
                    if (out_ready) begin
                        if (radix_r[1] && !prefix_second) begin
                            prefix_second <= 1'b1;
                            out_char      <= radix_r[0] ? 8'h36 : 8'h30;
                        end else begin
                            state    <= HASH1;
                            out_char <= 8'h23;
                        end
                    end
                end
                HASH1: begin
                    if (out_ready) begin
                        state    <= DIGITS;
                        out_char <= to_ascii(digits[n_dec[AW-1:0]]);
                    end
                end
                DIGITS: begin
                    if (out_ready) begin
                        if (n == N_ONE) begin
                            state    <= HASH2;
                            out_char <= 8'h23;
                            out_last <= 1'b1;
                        end else begin
                            n        <= n_dec;
                            out_char <= to_ascii(digits[n_dec2[AW-1:0]]);
                        end
                    end
                end
                HASH2: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        out_char  <= 8'h00;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_literal_formatter.sv
// Directed bench for literal_formatter: string content, out_last, latency, backpressure and reset.
module tb_literal_formatter;

    localparam int W = 16;

    logic         sysclk = 1'b0;
    logic         rstn = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] value = '0;
    logic [1:0]   radix = 2'b00;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [7:0]   out_char;
    logic         out_last;

    int errors = 0;
    int checks = 0;

    always #5 sysclk = ~sysclk;

    literal_formatter #(.W(W)) dut (
        .sysclk    (sysclk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .value     (value),
        .radix     (radix),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_char  (out_char),
        .out_last  (out_last)
    );

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Called #1 after a clock edge; returns #1 after the acceptance edge.
    task automatic apply_request(input logic [W-1:0] v, input logic [1:0] r);
        int guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge sysclk);
            #1;
            guard++;
        end
        check_output("req_ready", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        value    = v;
        radix    = r;
        @(posedge sysclk);
        #1;
        in_valid = 1'b0;
        value    = W'($urandom());
        radix    = 2'($urandom_range(0, 3));
        check_output("busy_in_ready", {31'b0, in_ready}, 32'd0);
    endtask

    task automatic receive_string(input string tag, input string exp, input int exp_latency,
                                  input bit random_ready, input bit inject);
        int         idx = 0;
        int         latency = -1;
        int         len = exp.len();
        bit         stalled = 1'b0;
        logic [7:0] held_char = 8'h00;
        logic       held_last = 1'b0;
        for (int cyc = 0; cyc < 400 && idx < len; cyc++) begin
            if (stalled) begin
                check_output({tag, "_hold_valid"}, {31'b0, out_valid}, 32'd1);
                check_output({tag, "_hold_char"}, {24'b0, out_char}, {24'b0, held_char});
                check_output({tag, "_hold_last"}, {31'b0, out_last}, {31'b0, held_last});
            end
            if (out_valid && latency < 0) latency = cyc;
            out_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (inject) begin
                in_valid = (cyc == 2 || cyc == 7);
                value    = 16'h0001;
                radix    = 2'b00;
            end
            stalled   = out_valid && !out_ready;
            held_char = out_char;
            held_last = out_last;
            if (out_valid && out_ready) begin
                check_output({tag, "_char"}, {24'b0, out_char}, {24'b0, exp[idx]});
                check_output({tag, "_last"}, {31'b0, out_last}, {31'b0, (idx == len - 1)});
                idx++;
            end
            @(posedge sysclk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_output({tag, "_beats"}, idx, len);
        check_output({tag, "_latency"}, latency, exp_latency);
        check_output({tag, "_done_ready"}, {31'b0, in_ready}, 32'd1);
        check_output({tag, "_done_valid"}, {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        int  beats;
        bit  seen;

        repeat (2) @(posedge sysclk);
        #1;
        check_output("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check_output("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check_output("rst_out_char", {24'b0, out_char}, 32'h00);
        check_output("rst_out_last", {31'b0, out_last}, 32'd0);
        rstn = 1'b1;
        @(posedge sysclk);
        #1;

        apply_request(16'h12AF, 2'b11);
        receive_string("hex", "16#12AF#", 4, 1'b0, 1'b0);

        apply_request(16'h0B77, 2'b00);
        receive_string("bin", "2#101101110111#", 12, 1'b0, 1'b0);

        apply_request(16'hFEF2, 2'b01);
        receive_string("oct", "8#177362#", 6, 1'b0, 1'b0);

        apply_request(16'd1234, 2'b10);
        receive_string("dec", "10#1234#", 68, 1'b0, 1'b0);

        apply_request(16'hFFFF, 2'b10);
        receive_string("decmax", "10#65535#", 85, 1'b0, 1'b0);

        apply_request(16'h0000, 2'b11);
        receive_string("zero", "16#0#", 1, 1'b0, 1'b0);

        apply_request(16'h8000, 2'b00);
        receive_string("full", "2#1000000000000000#", 16, 1'b0, 1'b0);

        // Random backpressure plus stray requests while busy.
        apply_request(16'h12AF, 2'b11);
        receive_string("bp", "16#12AF#", 4, 1'b1, 1'b1);
        out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid || !in_ready) seen = 1'b1;
            @(posedge sysclk);
            #1;
        end
        out_ready = 1'b0;
        check_output("bp_no_extra", {31'b0, seen}, 32'd0);

        apply_request(16'h12AF, 2'b11);
        out_ready = 1'b1;
        beats = 0;
        for (int cyc = 0; cyc < 50 && beats < 3; cyc++) begin
            if (out_valid) beats++;
            @(posedge sysclk);
            #1;
        end
        check_output("mid_digit_valid", {31'b0, out_valid}, 32'd1);
        check_output("mid_digit_char", {24'b0, out_char}, 32'h31);
        #3;
        rstn = 1'b0;
        #1;
        check_output("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check_output("midrst_out_char", {24'b0, out_char}, 32'h00);
        check_output("midrst_out_last", {31'b0, out_last}, 32'd0);
        check_output("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b0;
        repeat (2) @(posedge sysclk);
        #1;
        rstn = 1'b1;
        @(posedge sysclk);
        #1;
        check_output("postrst_quiet", {31'b0, out_valid}, 32'd0);

        apply_request(16'h002A, 2'b01);
        receive_string("afterrst", "8#52#", 2, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
